// File: rtl/cascade_master_drv.sv
// cascade_master_drv
// Master-side cascade driver for an 8259A-style interrupt controller.
// During an INTA sequence it counts INTA pulses. When the acknowledged IR
// has a slave attached, it drives that IR index (the slave ID) onto CAS[2:0].
// It also gates the master's own vector-byte drive.
//
// Optional feature: define CASCADE_TIMEOUT_EN to enable the inter-pulse
// timeout abort (limit set by TIMEOUT_CYCLES). When it is undefined, the
// W-states wait forever and seq_abort is tied low.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   intan         INTA strobe, active low, synchronous to clk
//   is_master     device is the cascade master
//   sngl          single mode (no cascading)
//   mode_8086     1: 2-pulse sequence, 0: 3-pulse (8080) sequence
//   icw3_slaves   bit i set = slave on IRi
//   ack_ir        IR index from the priority resolver
//   ack_valid     ack_ir is valid
//   cas_out       CAS drive value
//   cas_oe        CAS output enable
//   master_vec_en master may drive the vector byte(s)
//   inta_idx      current pulse number (0 = idle)
//   spurious      sequence began without a valid ack
//   seq_done      one-cycle pulse on normal completion
//   seq_abort     one-cycle pulse on timeout abort
//
// state | meaning
// IDLE  | no acknowledge sequence in progress
// P1    | first INTA pulse low
// W2    | waiting for second INTA fall
// P2    | second INTA pulse low
// W3    | waiting for third INTA fall (8080 only)
// P3    | third INTA pulse low (8080 only)
module cascade_master_drv #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       intan,
    input  logic       is_master,
    input  logic       sngl,
    input  logic       mode_8086,
    input  logic [7:0] icw3_slaves,
    input  logic [2:0] ack_ir,
    input  logic       ack_valid,
    output logic [2:0] cas_out,
    output logic       cas_oe,
    output logic       master_vec_en,
    output logic [1:0] inta_idx,
    output logic       spurious,
    output logic       seq_done,
    output logic       seq_abort
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        W2   = 3'd2,
        P2   = 3'd3,
        W3   = 3'd4,
        P3   = 3'd5
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("cascade_master_drv: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t     state_q, state_n;
    logic       intan_q;
    logic [2:0] ir_q, ir_n;
    logic       sel_q, sel_n;
    logic       spur_q, spur_n;
    logic       done_n, abort_n;
    logic       oe_n;
    logic       vec_n;
    logic [1:0] idx_n;
    logic       fall, rise;

    logic [2:0] cas_out_q;
    logic       cas_oe_q;
    logic       vec_q;
    logic [1:0] idx_q;
    logic       done_q;
    logic       abort_q;

    assign fall = intan_q & ~intan;
    assign rise = ~intan_q & intan;

`ifdef CASCADE_TIMEOUT_EN
    localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);
    logic [7:0] tmo_cnt_q;
`endif

    always_comb begin
        state_n = state_q;
        ir_n    = ir_q;
        sel_n   = sel_q;
        spur_n  = spur_q;
        done_n  = 1'b0;
        abort_n = 1'b0;
        case (state_q)
            IDLE: if (fall) begin
                state_n = P1;
                ir_n    = ack_valid ? ack_ir : 3'd7;
                spur_n  = ~ack_valid;
                sel_n   = is_master & ~sngl & icw3_slaves[ir_n];
            end
            P1: if (rise) state_n = W2;
            W2: if (fall) state_n = P2;
            P2: if (rise) begin
                if (mode_8086) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = W3;
                end
            end
            W3: if (fall) state_n = P3;
            P3: if (rise) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
`ifdef CASCADE_TIMEOUT_EN
        // A fall arriving on the limit cycle wins over the abort.
        if ((state_q == W2 || state_q == W3) && !fall &&
            ({1'b0, tmo_cnt_q} + 9'd1 == TMO_LIMIT)) begin
            state_n = IDLE;
            abort_n = 1'b1;
        end
`endif
    end

    // Output flops are loaded from next-state values, so that they are valid
    // immediately after the edge that detects the INTA transition.
    always_comb begin
        oe_n  = (state_n != IDLE) & sel_n;
        vec_n = (state_n == P2 || state_n == P3) & ~sel_n & is_master;
        case (state_n)
            P1, W2:  idx_n = 2'd1;
            P2, W3:  idx_n = 2'd2;
            P3:      idx_n = 2'd3;
            default: idx_n = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            intan_q   <= 1'b1;
            ir_q      <= 3'd0;
            sel_q     <= 1'b0;
            spur_q    <= 1'b0;
            cas_out_q <= 3'b000;
            cas_oe_q  <= 1'b0;
            vec_q     <= 1'b0;
            idx_q     <= 2'd0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            intan_q   <= intan;
            ir_q      <= ir_n;
            sel_q     <= sel_n;
            spur_q    <= spur_n;
            cas_out_q <= oe_n ? ir_n : 3'b000;
            cas_oe_q  <= oe_n;
            vec_q     <= vec_n;
            idx_q     <= idx_n;
            done_q    <= done_n;
            abort_q   <= abort_n;
        end
    end

`ifdef CASCADE_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_n != state_q) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_q == W2 || state_q == W3) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end else begin
            tmo_cnt_q <= 8'd0;
        end
    end
`endif

    assign cas_out       = cas_out_q;
    assign cas_oe        = cas_oe_q;
    assign master_vec_en = vec_q;
    assign inta_idx      = idx_q;
    assign spurious      = spur_q;
    assign seq_done      = done_q;
    assign seq_abort     = abort_q;

endmodule

// File: tb/tb_cascade_master_drv.sv
// Directed bench for cascade_master_drv. The output vector that each step
// compares is {cas_oe, cas_out[2:0], master_vec_en, inta_idx[1:0],
// spurious, seq_done, seq_abort}.
module tb_cascade_master_drv;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       intan = 1'b1;
    logic       is_master = 1'b1;
    logic       sngl = 1'b0;
    logic       mode_8086 = 1'b1;
    logic [7:0] icw3_slaves = 8'h00;
    logic [2:0] ack_ir = 3'd0;
    logic       ack_valid = 1'b1;
    logic [2:0] cas_out;
    logic       cas_oe;
    logic       master_vec_en;
    logic [1:0] inta_idx;
    logic       spurious;
    logic       seq_done;
    logic       seq_abort;

    int n_cmp = 0;
    int n_err = 0;

    cascade_master_drv #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .intan(intan), .is_master(is_master),
        .sngl(sngl), .mode_8086(mode_8086), .icw3_slaves(icw3_slaves),
        .ack_ir(ack_ir), .ack_valid(ack_valid), .cas_out(cas_out),
        .cas_oe(cas_oe), .master_vec_en(master_vec_en), .inta_idx(inta_idx),
        .spurious(spurious), .seq_done(seq_done), .seq_abort(seq_abort)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {cas_oe, cas_out, master_vec_en, inta_idx, spurious, seq_done, seq_abort};
    endfunction

    // exp(oe, out, vec, idx, spur, done, abort)
    function automatic logic [9:0] exp(input logic oe, input logic [2:0] o, input logic v,
                                       input logic [1:0] i, input logic s, input logic d,
                                       input logic a);
        return {oe, o, v, i, s, d, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        #1;
        e = exp(0, 3'd0, 0, 2'd0, 0, 0, 0);
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("FAIL reset_state got=%b want=%b", outs(), e);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("FAIL reset_release_idle got=%b want=%b", outs(), e);
        end
    endtask

    task automatic test_8086_slave();
        logic [9:0] e [5];
        logic       lv [5];
        e[0] = exp(1, 3'd2, 0, 2'd1, 0, 0, 0);
        e[1] = exp(1, 3'd2, 0, 2'd1, 0, 0, 0);
        e[2] = exp(1, 3'd2, 0, 2'd2, 0, 0, 0);
        e[3] = exp(0, 3'd0, 0, 2'd0, 0, 1, 0);
        e[4] = exp(0, 3'd0, 0, 2'd0, 0, 0, 0);
        lv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        is_master = 1; sngl = 0; mode_8086 = 1; icw3_slaves = 8'h04;
        ack_ir = 3'd2; ack_valid = 1;
        for (int k = 0; k < 5; k++) begin
            intan = lv[k];
            tick();
            n_cmp++;
            if (outs() !== e[k]) begin
                n_err++;
                $display("FAIL 8086_slave step%0d got=%b want=%b", k, outs(), e[k]);
            end
        end
    endtask

    task automatic test_8080_noslave();
        logic [9:0] e [7];
        logic       lv [7];
        e[0] = exp(0, 3'd0, 0, 2'd1, 0, 0, 0);
        e[1] = exp(0, 3'd0, 0, 2'd1, 0, 0, 0);
        e[2] = exp(0, 3'd0, 1, 2'd2, 0, 0, 0);
        e[3] = exp(0, 3'd0, 0, 2'd2, 0, 0, 0);
        e[4] = exp(0, 3'd0, 1, 2'd3, 0, 0, 0);
        e[5] = exp(0, 3'd0, 0, 2'd0, 0, 1, 0);
        e[6] = exp(0, 3'd0, 0, 2'd0, 0, 0, 0);
        lv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        mode_8086 = 0; icw3_slaves = 8'h00; ack_ir = 3'd5; ack_valid = 1;
        for (int k = 0; k < 7; k++) begin
            intan = lv[k];
            tick();
            n_cmp++;
            if (outs() !== e[k]) begin
                n_err++;
                $display("FAIL 8080_noslave step%0d got=%b want=%b", k, outs(), e[k]);
            end
        end
    endtask

    task automatic test_spurious();
        logic [9:0] e [4];
        logic       lv [4];
        e[0] = exp(1, 3'd7, 0, 2'd1, 1, 0, 0);
        e[1] = exp(1, 3'd7, 0, 2'd1, 1, 0, 0);
        e[2] = exp(1, 3'd7, 0, 2'd2, 1, 0, 0);
        e[3] = exp(0, 3'd0, 0, 2'd0, 1, 1, 0);
        lv = '{1'b0, 1'b1, 1'b0, 1'b1};
        mode_8086 = 1; icw3_slaves = 8'h80; ack_ir = 3'd3; ack_valid = 0;
        for (int k = 0; k < 4; k++) begin
            intan = lv[k];
            tick();
            if (k == 0) ack_valid = 1;
            n_cmp++;
            if (outs() !== e[k]) begin
                n_err++;
                $display("FAIL spurious step%0d got=%b want=%b", k, outs(), e[k]);
            end
        end
    endtask

    // Fall on the edge right after IDLE re-entry; also clears spurious.
    task automatic test_back_to_back();
        logic [9:0] e;
        icw3_slaves = 8'h02; ack_ir = 3'd1; ack_valid = 1;
        intan = 0;
        tick();
        e = exp(1, 3'd1, 0, 2'd1, 0, 0, 0);
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("FAIL back_to_back_p1 got=%b want=%b", outs(), e);
        end
        intan = 1; tick();
        intan = 0; tick();
        intan = 1; tick();
        e = exp(0, 3'd0, 0, 2'd0, 0, 1, 0);
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("FAIL back_to_back_done got=%b want=%b", outs(), e);
        end
        tick();
    endtask

    task automatic test_non_master();
        logic [9:0] e;
        is_master = 0; sngl = 0; mode_8086 = 1; icw3_slaves = 8'h04; ack_ir = 3'd2;
        intan = 0; tick();
        intan = 1; tick();
        intan = 0; tick();
        e = exp(0, 3'd0, 0, 2'd2, 0, 0, 0);
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("FAIL non_master_p2 got=%b want=%b", outs(), e);
        end
        intan = 1; tick(); tick();
        is_master = 1; sngl = 1;
        intan = 0; tick();
        intan = 1; tick();
        intan = 0; tick();
        e = exp(0, 3'd0, 1, 2'd2, 0, 0, 0);
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("FAIL single_mode_p2 got=%b want=%b", outs(), e);
        end
        intan = 1; tick(); tick();
        sngl = 0;
    endtask

    task automatic test_reset_mid();
        logic [9:0] e;
        mode_8086 = 1; icw3_slaves = 8'h04; ack_ir = 3'd2; ack_valid = 1;
        intan = 0; tick();
        intan = 1; tick();
        intan = 0; tick();
        e = exp(1, 3'd2, 0, 2'd2, 0, 0, 0);
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("FAIL pre_reset_p2 got=%b want=%b", outs(), e);
        end
        #1 rst = 1;
        #1;
        e = exp(0, 3'd0, 0, 2'd0, 0, 0, 0);
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("FAIL async_reset got=%b want=%b", outs(), e);
        end
        intan = 1;
        tick();
        rst = 0;
        tick();
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("FAIL post_reset_idle got=%b want=%b", outs(), e);
        end
        intan = 0; tick();
        e = exp(1, 3'd2, 0, 2'd1, 0, 0, 0);
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("FAIL post_reset_p1 got=%b want=%b", outs(), e);
        end
        intan = 1; tick();
        intan = 0; tick();
        intan = 1; tick(); tick();
    endtask

`ifdef CASCADE_TIMEOUT_EN
    task automatic test_timeout();
        logic [9:0] e;
        mode_8086 = 1; icw3_slaves = 8'h04; ack_ir = 3'd2; ack_valid = 1;
        intan = 0; tick();
        intan = 1; tick();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k < 4)       e = exp(1, 3'd2, 0, 2'd1, 0, 0, 0);
            else if (k == 4) e = exp(0, 3'd0, 0, 2'd0, 0, 0, 1);
            else             e = exp(0, 3'd0, 0, 2'd0, 0, 0, 0);
            n_cmp++;
            if (outs() !== e) begin
                n_err++;
                $display("FAIL timeout cycle%0d got=%b want=%b", k, outs(), e);
            end
        end
        intan = 0; tick();
        e = exp(1, 3'd2, 0, 2'd1, 0, 0, 0);
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("FAIL timeout_restart got=%b want=%b", outs(), e);
        end
        intan = 1; tick();
        intan = 0; tick();
        intan = 1; tick();
        e = exp(0, 3'd0, 0, 2'd0, 0, 1, 0);
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("FAIL timeout_restart_done got=%b want=%b", outs(), e);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_8086_slave();
        test_8080_noslave();
        test_spurious();
        test_back_to_back();
        test_non_master();
        test_reset_mid();
`ifdef CASCADE_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cascade_master_drv.md
# cascade_master_drv

Master-side cascade driver for the 8259A PIC. During an interrupt-acknowledge sequence it counts INTA pulses and, when the acknowledged IR input has a slave attached, drives that slave's 3-bit ID onto CAS[2:0]. Each slave's cascade comparator matches CAS against its own ID. The block sits between the priority resolver and the CAS pins, and gates the master's own vector-byte drive.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum clk cycles allowed between INTA pulses before the sequence aborts. Used only with `CASCADE_TIMEOUT_EN`. Range 1..255.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `intan` in 1: INTA strobe, active low, already synchronous to `clk`.
- `is_master` in 1: device is the cascade master (SPENn high, or buffered-mode master).
- `sngl` in 1: ICW1 single mode; no cascading when 1.
- `mode_8086` in 1: 1 selects a 2-pulse sequence; 0 selects a 3-pulse (8080) sequence.
- `icw3_slaves` in 8: ICW3 master mask; bit i = 1 means a slave is on IRi.
- `ack_ir` in 3: IR index chosen by the priority resolver.
- `ack_valid` in 1: `ack_ir` is valid.
- `cas_out` out 3: CAS drive value.
- `cas_oe` out 1: CAS output enable.
- `master_vec_en` out 1: master may drive vector byte(s) on the data bus.
- `inta_idx` out 2: current pulse number, 0 = idle, 1..3.
- `spurious` out 1: sequence began with `ack_valid` = 0.
- `seq_done` out 1: one-cycle pulse when the sequence completes normally.
- `seq_abort` out 1: one-cycle pulse when a timeout abort occurs.

## Operation
- A one-flop history `intan_q` detects edges; it resets to 1.
  - fall = `intan_q` & ~`intan`.
  - rise = ~`intan_q` & `intan`.
- States: IDLE, P1, W2, P2, W3, P3.
- IDLE, on fall → P1:
  - `ir_q` latches `ack_ir` if `ack_valid`, otherwise latches 7 and sets `spurious`.
  - `sel_q` latches `is_master` & ~`sngl` & `icw3_slaves[ir]`.
- P1: on rise → W2.
- W2: on fall → P2.
- P2, on rise:
  - if `mode_8086`: → IDLE and pulse `seq_done`.
  - otherwise: → W3.
- W3: on fall → P3.
- P3: on rise → IDLE and pulse `seq_done`.
- CAS drive:
  - `cas_oe` = `sel_q` whenever state ≠ IDLE.
  - `cas_out` = `ir_q` when `cas_oe` = 1; otherwise 3'b000.
- `master_vec_en` = ~`sel_q` in P2 or P3 (vector bytes only; never in P1). It is always 0 when `is_master` = 0.
- `inta_idx` values:
  - 1 in P1 and W2.
  - 2 in P2 and W3.
  - 3 in P3.
  - 0 in IDLE.
- `spurious` holds its value until the next IDLE→P1 transition.
- A fall is ignored in P-states and a rise is ignored in W-states (glitch tolerance).
- `mode_8086`, `sngl` and `icw3_slaves` are sampled live. Software must not change them mid-sequence; `sel_q` stays frozen for the rest of the sequence.

## Timing
- All outputs are registered. Reset value:
  - outputs: all 0, `cas_out` = 000.
  - internal: state = IDLE, `intan_q` = 1.
- If fall is detected at edge k:
  - `cas_oe`, `cas_out` and `inta_idx` = 1 are valid after edge k.
  - `ack_ir` is sampled at edge k.
- Final rise detected at edge m:
  - `cas_oe` drops after edge m.
  - `seq_done` is high for the cycle after edge m.
- Minimum pulse low or high time is 1 clk.
- A back-to-back sequence may start with a fall on the edge immediately after IDLE is re-entered.
- Asserting `rst` mid-sequence forces IDLE and releases CAS immediately, without waiting for a clock edge.

## Configuration
- `CASCADE_TIMEOUT_EN` defined:
  - An 8-bit counter clears on every state change and increments in W2 and W3.
  - When it reaches `TIMEOUT_CYCLES`, the block returns to IDLE, drops `cas_oe` and pulses `seq_abort` for 1 cycle.
- `CASCADE_TIMEOUT_EN` undefined: no counter, no abort path; W-states wait indefinitely and `seq_abort` is tied to 0.

## Test plan
- 8086 mode, master, `sngl` = 0, `icw3_slaves` = 8'h04, `ack_ir` = 2:
  - `cas_out` = 010 and `cas_oe` = 1 from the first fall through the second rise.
  - `master_vec_en` = 0 throughout.
  - `seq_done` pulses once after the second rise.
- 8080 mode, `icw3_slaves` = 8'h00, `ack_ir` = 5:
  - `cas_oe` = 0 for the whole sequence.
  - `master_vec_en` = 1 in P2 and P3.
  - `inta_idx` steps 1,1,2,2,3,0.
- `ack_valid` = 0 at the first fall with `icw3_slaves` = 8'h80: `spurious` = 1 and `cas_out` = 111.
- Assert `rst` during P2 with `cas_oe` = 1:
  - all outputs go to 0 asynchronously.
  - the next fall after reset release starts a fresh P1.
- With `CASCADE_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, hold `intan` high in W2 for 10 cycles:
  - `seq_abort` pulses after the 4th W2 cycle and `cas_oe` drops.
  - a later rise/fall restarts from IDLE.
